// File: rtl/sram_responder.sv
// sram_responder: shared-word on-chip memory serving a read-only inst port and a byte-writable data port.
// Both ports have 1-cycle read latency, and the block counts out-of-range and illegal accesses.
`default_nettype none

module sram_responder #(
  parameter int          ADDR_W = 16,
  parameter logic [31:0] BASE   = 32'h1c00_0000,
  parameter int          CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_we,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              err_valid,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [31:0] WORDS   = 32'(DEPTH);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [31:0] mem [0:DEPTH-1];

  logic [31:0]       inst_off;
  logic [31:0]       data_off;
  logic              inst_hit;
  logic              data_hit;
  logic [ADDR_W-1:0] inst_idx;
  logic [ADDR_W-1:0] data_idx;
  logic              inst_err;
  logic              data_err;
  logic              data_wr;
  logic [CNT_W:0]    err_sum;
  logic              unused_bits;

  // Offset wraps modulo 2**32, so the lower bound must be checked on the raw address.
  assign inst_off = inst_sram_addr - BASE;
  assign data_off = data_sram_addr - BASE;
  assign inst_hit = (inst_sram_addr >= BASE) && ({2'b00, inst_off[31:2]} < WORDS);
  assign data_hit = (data_sram_addr >= BASE) && ({2'b00, data_off[31:2]} < WORDS);
  assign inst_idx = inst_off[ADDR_W+1:2];
  assign data_idx = data_off[ADDR_W+1:2];

  assign inst_err = inst_sram_en && (!inst_hit || (inst_sram_we != 4'h0));
  assign data_err = data_sram_en && !data_hit;
  assign data_wr  = data_sram_en && data_hit && (data_sram_we != 4'h0);

  assign err_sum = {1'b0, err_cnt} + (CNT_W+1)'(inst_err) + (CNT_W+1)'(data_err);

  assign unused_bits = ^{inst_sram_wdata, inst_off[1:0], data_off[1:0]};

  // Storage has no reset so the array stays inferable as block RAM.
  always_ff @(posedge clk) begin
    if (!reset && data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_we[b]) begin
          mem[data_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads sample the array before this edge's write lands (read-first on both ports).
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
    end else begin
      if (inst_sram_en) begin
        inst_sram_rdata <= inst_hit ? mem[inst_idx] : 32'h0;
      end
      if (data_sram_en) begin
        data_sram_rdata <= data_hit ? mem[data_idx] : 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_valid <= inst_err || data_err;
      err_cnt   <= (err_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : err_sum[CNT_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed scenarios plus randomized traffic against a word-level model of the memory.
`default_nettype none

module tb_sram_responder;

  localparam int          ADDR_W = 16;
  localparam logic [31:0] BASE   = 32'h1c00_0000;
  localparam int          CNT_W  = 8;
  localparam int          SAT    = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        err_valid;
  logic [CNT_W-1:0] err_cnt;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;
  logic [31:0] model [int];

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .err_valid(err_valid), .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_sram_en = 1'b0; inst_sram_we = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
    data_sram_en = 1'b0; data_sram_we = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
  endtask

  task automatic dwrite(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    idle();
    data_sram_en = 1'b1; data_sram_we = we; data_sram_addr = addr; data_sram_wdata = wd;
    tick();
    idle();
  endtask

  function automatic bit in_range(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < (longint'(4) * (longint'(1) << ADDR_W)));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic int sat_add(input int c, input int e);
    return (c + e > SAT) ? SAT : c + e;
  endfunction

  task automatic test_reset();
    idle();
    reset = 1'b1;
    inst_sram_en = 1'b1; inst_sram_we = 4'h1; inst_sram_addr = BASE - 4;
    data_sram_en = 1'b1; data_sram_we = 4'hf; data_sram_addr = BASE; data_sram_wdata = 32'h1234_5678;
    tick(); tick();
    total++; if (inst_sram_rdata !== 32'h0) $display("FAIL reset_inst_rdata got %h want 0", inst_sram_rdata); else passed++;
    total++; if (data_sram_rdata !== 32'h0) $display("FAIL reset_data_rdata got %h want 0", data_sram_rdata); else passed++;
    total++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid got %b want 0", err_valid); else passed++;
    total++; if (err_cnt !== '0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else passed++;
    idle();
    reset = 1'b0;
    dwrite(BASE + 4, 4'hf, 32'ha5a5_0f0f);
    model[1] = 32'ha5a5_0f0f;
    reset = 1'b1;
    data_sram_en = 1'b1; data_sram_we = 4'hf; data_sram_addr = BASE + 4; data_sram_wdata = 32'hffff_ffff;
    tick();
    reset = 1'b0;
    idle();
    data_sram_en = 1'b1; data_sram_addr = BASE + 4;
    tick();
    idle();
    total++; if (data_sram_rdata !== 32'ha5a5_0f0f) $display("FAIL reset_blocks_write got %h want a5a50f0f", data_sram_rdata); else passed++;
    total++; if (err_cnt !== '0) $display("FAIL reset_no_error got %0d want 0", err_cnt); else passed++;
  endtask

  task automatic test_write_read();
    dwrite(BASE + 8, 4'hf, 32'hdead_beef);
    model[2] = 32'hdead_beef;
    inst_sram_en = 1'b1; inst_sram_addr = BASE + 8;
    tick();
    idle();
    total++; if (inst_sram_rdata !== 32'hdead_beef) $display("FAIL inst_read got %h want deadbeef", inst_sram_rdata); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (inst_sram_rdata !== 32'hdead_beef) $display("FAIL inst_hold got %h want deadbeef", inst_sram_rdata); else passed++;
    end
  endtask

  task automatic test_byte_strobes();
    dwrite(BASE + 12, 4'hf, 32'h1122_3344);
    data_sram_en = 1'b1; data_sram_we = 4'b0101; data_sram_addr = BASE + 12; data_sram_wdata = 32'haabb_ccdd;
    tick();
    idle();
    total++; if (data_sram_rdata !== 32'h1122_3344) $display("FAIL read_first got %h want 11223344", data_sram_rdata); else passed++;
    data_sram_en = 1'b1; data_sram_addr = BASE + 12;
    tick();
    idle();
    total++; if (data_sram_rdata !== 32'h11bb_33dd) $display("FAIL byte_strobe got %h want 11bb33dd", data_sram_rdata); else passed++;
    model[3] = 32'h11bb_33dd;
  endtask

  task automatic test_same_edge();
    dwrite(BASE + 16, 4'hf, 32'h0);
    data_sram_en = 1'b1; data_sram_we = 4'hf; data_sram_addr = BASE + 16; data_sram_wdata = 32'h5555_5555;
    inst_sram_en = 1'b1; inst_sram_addr = BASE + 16;
    tick();
    idle();
    total++; if (inst_sram_rdata !== 32'h0) $display("FAIL cross_port_old got %h want 0", inst_sram_rdata); else passed++;
    inst_sram_en = 1'b1; inst_sram_addr = BASE + 16;
    tick();
    idle();
    total++; if (inst_sram_rdata !== 32'h5555_5555) $display("FAIL cross_port_new got %h want 55555555", inst_sram_rdata); else passed++;
    model[4] = 32'h5555_5555;
  endtask

  task automatic test_errors();
    data_sram_en = 1'b1; data_sram_addr = BASE - 4;
    inst_sram_en = 1'b1; inst_sram_we = 4'h1; inst_sram_addr = BASE + 8; inst_sram_wdata = 32'h0bad_f00d;
    tick();
    idle();
    exp_cnt = sat_add(exp_cnt, 2);
    total++; if (data_sram_rdata !== 32'h0) $display("FAIL oor_data_rdata got %h want 0", data_sram_rdata); else passed++;
    total++; if (inst_sram_rdata !== 32'hdead_beef) $display("FAIL inst_we_reads got %h want deadbeef", inst_sram_rdata); else passed++;
    total++; if (err_valid !== 1'b1) $display("FAIL err_pulse got %b want 1", err_valid); else passed++;
    total++; if (err_cnt !== CNT_W'(exp_cnt)) $display("FAIL err_cnt_plus2 got %0d want %0d", err_cnt, exp_cnt); else passed++;
    tick();
    total++; if (err_valid !== 1'b0) $display("FAIL err_pulse_end got %b want 0", err_valid); else passed++;
    // Write just past the top must not alias onto a low word.
    dwrite(BASE + (32'd4 << ADDR_W) + 8, 4'hf, 32'h7777_7777);
    exp_cnt = sat_add(exp_cnt, 1);
    total++; if (data_sram_rdata !== 32'h0) $display("FAIL oor_high_rdata got %h want 0", data_sram_rdata); else passed++;
    total++; if (err_cnt !== CNT_W'(exp_cnt)) $display("FAIL err_cnt_high got %0d want %0d", err_cnt, exp_cnt); else passed++;
    inst_sram_en = 1'b1; inst_sram_addr = BASE + 8;
    tick();
    idle();
    total++; if (inst_sram_rdata !== 32'hdead_beef) $display("FAIL mem_unchanged got %h want deadbeef", inst_sram_rdata); else passed++;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) != 0) return BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
    case ($urandom_range(0, 2))
      0:       return BASE - 4 * $urandom_range(1, 100) + $urandom_range(0, 3);
      1:       return BASE + (32'd4 << ADDR_W) + $urandom_range(0, 400);
      default: return $urandom_range(0, 32'h1bff_ffff);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] exp_i, exp_d, w;
    int e;
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      dwrite(BASE + 4 * k, 4'hf, w);
      model[k] = w;
    end
    exp_i = inst_sram_rdata;
    exp_d = data_sram_rdata;
    for (int n = 0; n < 400; n++) begin
      inst_sram_en = ($urandom_range(0, 3) != 0);
      inst_sram_we = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      inst_sram_addr = rand_addr();
      inst_sram_wdata = $urandom;
      data_sram_en = ($urandom_range(0, 3) != 0);
      data_sram_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      data_sram_addr = rand_addr();
      data_sram_wdata = $urandom;
      e = 0;
      if (inst_sram_en) begin
        exp_i = in_range(inst_sram_addr) ? model[word_of(inst_sram_addr)] : 32'h0;
        if (!in_range(inst_sram_addr) || inst_sram_we != 4'h0) e++;
      end
      if (data_sram_en) begin
        if (in_range(data_sram_addr)) begin
          exp_d = model[word_of(data_sram_addr)];
          w = exp_d;
          for (int b = 0; b < 4; b++)
            if (data_sram_we[b]) w[8*b +: 8] = data_sram_wdata[8*b +: 8];
          model[word_of(data_sram_addr)] = w;
        end else begin
          exp_d = 32'h0;
          e++;
        end
      end
      exp_cnt = sat_add(exp_cnt, e);
      tick();
      total++; if (inst_sram_rdata !== exp_i) $display("FAIL rand_inst n=%0d got %h want %h", n, inst_sram_rdata, exp_i); else passed++;
      total++; if (data_sram_rdata !== exp_d) $display("FAIL rand_data n=%0d got %h want %h", n, data_sram_rdata, exp_d); else passed++;
      total++; if (err_valid !== (e != 0)) $display("FAIL rand_err_valid n=%0d got %b want %b", n, err_valid, (e != 0)); else passed++;
      total++; if (err_cnt !== CNT_W'(exp_cnt)) $display("FAIL rand_err_cnt n=%0d got %0d want %0d", n, err_cnt, exp_cnt); else passed++;
    end
    idle();
    tick();
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      data_sram_en = 1'b1; data_sram_addr = BASE - 4;
      tick();
      exp_cnt = sat_add(exp_cnt, 1);
      total++; if (err_valid !== 1'b1) $display("FAIL sat_err_valid n=%0d got %b want 1", n, err_valid); else passed++;
      total++; if (err_cnt !== CNT_W'(exp_cnt)) $display("FAIL sat_err_cnt n=%0d got %0d want %0d", n, err_cnt, exp_cnt); else passed++;
    end
    idle();
    tick();
    total++; if (err_cnt !== CNT_W'(SAT)) $display("FAIL sat_final got %0d want %0d", err_cnt, SAT); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_same_edge();
    test_errors();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
